seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 100000, clock cycles each digit is held active; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  one-cycle request to display value/dp_in.
REQ-005 value  input  16  four hex nibbles; nibble i = value[4i+3:4i] is shown on digit i.
REQ-006 dp_in  input  4  decimal-point enable per digit, bit i = digit i.
REQ-007 blank_lz  input  1  level; 1 enables leading-zero blanking.
REQ-008 digit_sel  output  2  index of the active digit; drives the existing 2-to-4 anode decoder.
REQ-009 digit_val  output  4  nibble for the active digit, consumed by the segment encoder.
REQ-010 dp  output  1  decimal point for the active digit.
REQ-011 blank  output  1  1 = active digit off (all segments dark).
REQ-012 load_ack  output  1  one-cycle pulse when the pending load is committed to the display.
REQ-013 frame_done  output  1  one-cycle pulse when digit 3 hands over to digit 0.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 and wraps; tick = (count == PRESCALE-1).
REQ-015 On tick, digit_sel increments modulo 4 (3 -> 0 wrap); otherwise it holds.
REQ-016 Boundary = tick while digit_sel == 3; frame_done pulses in the cycle after the boundary.
REQ-017 load captures value/dp_in into a pending register and sets a pending flag; display register is unchanged.
REQ-018 Repeated load before a boundary overwrites pending (newest wins); only one load_ack is issued.
REQ-019 At a boundary with the pending flag set: pending copies to the display register, flag clears, load_ack pulses the next cycle.
REQ-020 load in the same cycle as a boundary commits that cycle's value/dp_in directly (no frame delay); load_ack pulses the next cycle.
REQ-021 digit_val, dp and blank are registered and change on the same edge as digit_sel, so all four outputs are consistent.
REQ-022 Blanking: digit i (i = 1..3) is blanked when blank_lz = 1 and display nibbles i..3 are all zero; digit 0 is never blanked.
REQ-023 A blanked digit drives digit_val = 0 and dp = 0.
REQ-024 With blank_lz = 0, blank = 0 always.

Reset
REQ-025 While reset = 1: prescaler = 0; digit_sel = 0; display and pending registers = 0; pending flag = 0.
REQ-026 Reset outputs: digit_val = 0; dp = 0; blank = 0; load_ack = 0; frame_done = 0.
REQ-027 Reset takes priority over load and tick; a pending load is discarded without load_ack.

Structure
REQ-028 Shared package seven_seg_pkg holds DIGITS = 4, NIBBLE_W = 4, SEL_W = 2 and the PRESCALE default.
REQ-029 Prescaler is a sub-module, tick_gen (parameter PRESCALE; ports clk, reset, tick).
REQ-030 Scan, load commit and blanking logic stay in seven_seg_scan_ctrl; no combinational path from inputs to outputs.

Verification (bench uses PRESCALE = 4)
REQ-031 reset -> all outputs 0, digit_sel = 0; after release, digit_sel steps 0,1,2,3,0 every 4 cycles; frame_done pulses once per 16 cycles.
REQ-032 load 0x1234 mid-frame -> display unchanged until the boundary; load_ack single pulse; next frame digit_val = 4,3,2,1 for digit_sel 0..3.
REQ-033 load 0xAAAA then load 0x00F0 in the same frame -> only 0x00F0 is shown; exactly one load_ack.
REQ-034 blank_lz = 1, value 0x0005 -> blank = 1 on digits 3,2,1; digit 0 shows 5. Value 0x0000 -> digit 0 shows 0 with blank = 0. Value 0x0100 -> only digit 3 blanked.
REQ-035 load 0xBEEF on the boundary cycle -> next frame shows F,E,E,B; load_ack the following cycle.
REQ-036 reset while digit_sel = 2 with a load pending -> next cycle all reset values; no load_ack; display shows 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants, types and the leading-zero blanking helper for the
// four-digit seven-segment scan controller.
package seven_seg_pkg;

  localparam int unsigned DIGITS           = 4;
  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned SEL_W            = 2;
  localparam int unsigned PRESCALE_DEFAULT = 100000;
  localparam int unsigned VALUE_W          = DIGITS * NIBBLE_W;

  typedef logic [SEL_W-1:0] sel_t;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [DIGITS-1:0]  dp;
  } disp_t;

  // Digit sel is dark when it and every more-significant nibble are zero;
  // digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lz_blank(input logic [VALUE_W-1:0] v, input sel_t sel);
    logic b;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((i >= 32'(sel)) && (v[i*NIBBLE_W +: NIBBLE_W] != '0)) b = 1'b0;
    end
    if (sel == '0) b = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the terminal count.
module tick_gen
  import seven_seg_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset)     r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with frame-synchronous load commit
// and optional leading-zero blanking; all outputs are registered.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [VALUE_W-1:0]  value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  output logic [SEL_W-1:0]    digit_sel,
  output logic [NIBBLE_W-1:0] digit_val,
  output logic                dp,
  output logic                blank,
  output logic                load_ack,
  output logic                frame_done
);

  logic  w_tick;
  logic  w_boundary;
  sel_t  w_sel_nxt;
  disp_t w_disp_nxt;
  logic  w_blank_nxt;
  logic  [NIBBLE_W-1:0] w_val_nxt;
  logic  w_dp_nxt;

  sel_t  r_sel;
  disp_t r_disp;
  disp_t r_pend;
  logic  r_pend_vld;
  logic  [NIBBLE_W-1:0] r_val;
  logic  r_dp;
  logic  r_blank;
  logic  r_load_ack;
  logic  r_frame_done;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Digit outputs are computed from next-state sel/display so they update on
  // the same edge as digit_sel, including the frame where a load commits.
  always_comb begin
    w_boundary = w_tick && (r_sel == sel_t'(DIGITS - 1));
    w_sel_nxt  = w_tick ? r_sel + sel_t'(1) : r_sel;
    w_disp_nxt = r_disp;
    if (w_boundary) begin
      if (load)            w_disp_nxt = '{value: value, dp: dp_in};
      else if (r_pend_vld) w_disp_nxt = r_pend;
    end
    w_blank_nxt = blank_lz && lz_blank(w_disp_nxt.value, w_sel_nxt);
    w_val_nxt   = w_blank_nxt ? '0 : w_disp_nxt.value[32'(w_sel_nxt)*NIBBLE_W +: NIBBLE_W];
    w_dp_nxt    = w_blank_nxt ? 1'b0 : w_disp_nxt.dp[w_sel_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_val        <= '0;
      r_dp         <= 1'b0;
      r_blank      <= 1'b0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_disp       <= w_disp_nxt;
      r_val        <= w_val_nxt;
      r_dp         <= w_dp_nxt;
      r_blank      <= w_blank_nxt;
      r_load_ack   <= w_boundary && (load || r_pend_vld);
      r_frame_done <= w_boundary;
      if (w_boundary) begin
        r_pend_vld <= 1'b0;
      end else if (load) begin
        r_pend     <= '{value: value, dp: dp_in};
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign digit_sel  = r_sel;
  assign digit_val  = r_val;
  assign dp         = r_dp;
  assign blank      = r_blank;
  assign load_ack   = r_load_ack;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with PRESCALE = 4 (one digit per
// 4 cycles, one frame per 16 cycles); cyc counts rising edges since reset release.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        dp;
  logic        blank;
  logic        load_ack;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acks   = 0;
  int ack0   = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .digit_sel  (digit_sel),
    .digit_val  (digit_val),
    .dp         (dp),
    .blank      (blank),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs set before the call are seen
  // by the rising edge crossed here.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (load_ack === 1'b1) acks++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_digit(input string tag, input logic [1:0] sel, input logic [3:0] val,
                           input logic dpx, input logic blk);
    chk({tag, ".sel"},   digit_sel, sel);
    chk({tag, ".val"},   digit_val, val);
    chk({tag, ".dp"},    dp,        dpx);
    chk({tag, ".blank"}, blank,     blk);
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b1;
    value    = 16'hFFFF;
    dp_in    = 4'hF;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk_digit("rst", 2'd0, 4'h0, 1'b0, 1'b0);
    chk("rst.load_ack",   load_ack,   1'b0);
    chk("rst.frame_done", frame_done, 1'b0);

    load  = 1'b0;
    reset = 1'b0;
    cyc   = 0;
    acks  = 0;

    // Scan sequence and frame pulses over two frames
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("scan.sel",        digit_sel,  16'((cyc / 4) % 4));
      chk("scan.frame_done", frame_done, 16'(cyc % 16 == 0));
      chk("scan.val",        digit_val,  4'h0);
    end
    chk("scan.no_ack", 16'(acks), 16'd0);

    // Mid-frame load waits for the boundary at edge 48
    run_to(37);
    ack0  = acks;
    load  = 1'b1;
    value = 16'h1234;
    dp_in = 4'b0000;
    step();
    load  = 1'b0;
    chk_digit("ld1.held", 2'd1, 4'h0, 1'b0, 1'b0);
    run_to(47);
    chk_digit("ld1.pre", 2'd3, 4'h0, 1'b0, 1'b0);
    chk("ld1.pre_ack", load_ack, 1'b0);
    step();
    chk_digit("ld1.d0", 2'd0, 4'h4, 1'b0, 1'b0);
    chk("ld1.ack", load_ack, 1'b1);
    chk("ld1.fd",  frame_done, 1'b1);
    run_to(52); chk_digit("ld1.d1", 2'd1, 4'h3, 1'b0, 1'b0);
    run_to(56); chk_digit("ld1.d2", 2'd2, 4'h2, 1'b0, 1'b0);
    run_to(60); chk_digit("ld1.d3", 2'd3, 4'h1, 1'b0, 1'b0);
    chk("ld1.ack_count", 16'(acks - ack0), 16'd1);

    // Two loads in one frame: newest wins, one acknowledge at edge 80
    run_to(65);
    ack0  = acks;
    load  = 1'b1;
    value = 16'hAAAA;
    dp_in = 4'b1111;
    step();
    load  = 1'b0;
    run_to(70);
    load  = 1'b1;
    value = 16'h00F0;
    dp_in = 4'b0000;
    step();
    load  = 1'b0;
    run_to(79); chk_digit("ld2.pre", 2'd3, 4'h1, 1'b0, 1'b0);
    run_to(80); chk_digit("ld2.d0", 2'd0, 4'h0, 1'b0, 1'b0);
    chk("ld2.ack", load_ack, 1'b1);
    run_to(84); chk_digit("ld2.d1", 2'd1, 4'hF, 1'b0, 1'b0);
    run_to(88); chk_digit("ld2.d2", 2'd2, 4'h0, 1'b0, 1'b0);
    run_to(92); chk_digit("ld2.d3", 2'd3, 4'h0, 1'b0, 1'b0);
    chk("ld2.ack_count", 16'(acks - ack0), 16'd1);

    // Leading-zero blanking: 0x0005 commits at edge 96
    blank_lz = 1'b1;
    run_to(93);
    load  = 1'b1;
    value = 16'h0005;
    dp_in = 4'b1111;
    step();
    load  = 1'b0;
    run_to(96);  chk_digit("lz5.d0", 2'd0, 4'h5, 1'b1, 1'b0);
    run_to(100); chk_digit("lz5.d1", 2'd1, 4'h0, 1'b0, 1'b1);
    run_to(104); chk_digit("lz5.d2", 2'd2, 4'h0, 1'b0, 1'b1);
    run_to(108); chk_digit("lz5.d3", 2'd3, 4'h0, 1'b0, 1'b1);

    // 0x0000 commits at edge 112
    run_to(109);
    load  = 1'b1;
    value = 16'h0000;
    dp_in = 4'b0000;
    step();
    load  = 1'b0;
    run_to(112); chk_digit("lz0.d0", 2'd0, 4'h0, 1'b0, 1'b0);
    run_to(116); chk_digit("lz0.d1", 2'd1, 4'h0, 1'b0, 1'b1);

    // 0x0100 commits at edge 128: only digit 3 dark
    run_to(117);
    load  = 1'b1;
    value = 16'h0100;
    step();
    load  = 1'b0;
    run_to(128); chk_digit("lz1.d0", 2'd0, 4'h0, 1'b0, 1'b0);
    run_to(132); chk_digit("lz1.d1", 2'd1, 4'h0, 1'b0, 1'b0);
    run_to(136); chk_digit("lz1.d2", 2'd2, 4'h1, 1'b0, 1'b0);
    run_to(140); chk_digit("lz1.d3", 2'd3, 4'h0, 1'b0, 1'b1);

    // Load on the boundary edge (144) commits immediately
    blank_lz = 1'b0;
    run_to(143);
    chk_digit("bnd.pre", 2'd3, 4'h0, 1'b0, 1'b0);
    ack0  = acks;
    load  = 1'b1;
    value = 16'hBEEF;
    dp_in = 4'b0001;
    step();
    load  = 1'b0;
    chk_digit("bnd.d0", 2'd0, 4'hF, 1'b1, 1'b0);
    chk("bnd.ack", load_ack,   1'b1);
    chk("bnd.fd",  frame_done, 1'b1);
    run_to(148); chk_digit("bnd.d1", 2'd1, 4'hE, 1'b0, 1'b0);
    run_to(152); chk_digit("bnd.d2", 2'd2, 4'hE, 1'b0, 1'b0);
    run_to(156); chk_digit("bnd.d3", 2'd3, 4'hB, 1'b0, 1'b0);
    chk("bnd.ack_count", 16'(acks - ack0), 16'd1);

    // Reset during digit 2 with a load pending discards it
    run_to(165);
    load  = 1'b1;
    value = 16'h5678;
    dp_in = 4'b1111;
    step();
    load  = 1'b0;
    run_to(169);
    chk("rst2.pre_sel", digit_sel, 2'd2);
    reset = 1'b1;
    step();
    chk_digit("rst2", 2'd0, 4'h0, 1'b0, 1'b0);
    chk("rst2.load_ack",   load_ack,   1'b0);
    chk("rst2.frame_done", frame_done, 1'b0);
    reset = 1'b0;
    cyc   = 0;
    ack0  = acks;
    run_to(4);  chk_digit("rst2.d1", 2'd1, 4'h0, 1'b0, 1'b0);
    run_to(8);  chk_digit("rst2.d2", 2'd2, 4'h0, 1'b0, 1'b0);
    run_to(12); chk_digit("rst2.d3", 2'd3, 4'h0, 1'b0, 1'b0);
    run_to(16); chk_digit("rst2.d0", 2'd0, 4'h0, 1'b0, 1'b0);
    chk("rst2.fd",        frame_done, 1'b1);
    chk("rst2.ack_count", 16'(acks - ack0), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
